rs232_rx: RTL

- UART receiver: the counterpart of the rs232_tx serializer. Lets the board accept bytes from the host PC over the same serial link, e.g. commands to trigger ADC acquisition or select a channel.
- Deserializes one frame at a time: start bit, 8 data bits LSB first, optional parity bit, 1 stop bit.
- Presents each byte with a one-cycle valid tick plus parity and framing error flags.
- Runs on the 100 MHz system clock. Bit timing comes from an internal divider counter; no external tick.

---
 rtl/rs232_rx.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/rs232_rx.sv
// -----------------------------------------------------------------------------
// rs232_rx : UART receiver (start bit, DATA_BITS data LSB first, optional
//            parity bit, one stop bit). Bit timing comes from an internal
//            divider; rx_i is synchronized through two flops before use.
//
// Ports
//   clk_i      system clock, rising edge
//   rst_i      asynchronous reset, active high
//   rx_i       serial line, idle high, asynchronous to clk_i
//   data_o     last received word, held until the next completed frame
//   rx_done_o  one-cycle pulse when a frame completes
//   par_err_o  parity error of the last frame (held)
//   frm_err_o  stop bit sampled low in the last frame (held)
//   busy_o     high while the receiver is not idle
// -----------------------------------------------------------------------------
module rs232_rx #(
    parameter int BAUD_DIV   = 10415,
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 rx_i,
    output logic [DATA_BITS-1:0] data_o,
    output logic                 rx_done_o,
    output logic                 par_err_o,
    output logic                 frm_err_o,
    output logic                 busy_o
);

    localparam int CNT_W = $clog2(BAUD_DIV);
    localparam int IDX_W = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(BAUD_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
    } state_t;

    state_t                 state_q, state_d;
    logic                   rx_meta_q, rx_s_q;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   par_bit_q, par_bit_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   done_q, done_d;
    logic                   par_err_q, par_err_d;
    logic                   frm_err_q, frm_err_d;
    logic                   par_calc;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            // Synchronizer resets to the idle line level so that reset
            // release never looks like a start edge.
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            par_bit_q <= 1'b0;
            data_q    <= '0;
            done_q    <= 1'b0;
            par_err_q <= 1'b0;
            frm_err_q <= 1'b0;
        end else begin
            rx_meta_q <= rx_i;
            rx_s_q    <= rx_meta_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            par_bit_q <= par_bit_d;
            data_q    <= data_d;
            done_q    <= done_d;
            par_err_q <= par_err_d;
            frm_err_q <= frm_err_d;
        end
    end

    // XOR of data and received parity bit: 0 means an even number of ones.
    assign par_calc = (^shift_q) ^ par_bit_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        idx_d     = idx_q;
        shift_d   = shift_q;
        par_bit_d = par_bit_q;
        data_d    = data_q;
        done_d    = 1'b0;
        par_err_d = par_err_q;
        frm_err_d = frm_err_q;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!rx_s_q) state_d = S_START;
            end
            S_START: begin
                // Re-check the line half a bit in; a high level means glitch.
                if (cnt_q == CNT_HALF) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DATA;
                        idx_d   = '0;
                    end
                end
            end
            S_DATA: begin
                // Counter was cleared mid start bit, so a full bit period
                // lands in the middle of each data bit.
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
                    idx_d   = idx_q + 1'b1;
                    if (idx_q == IDX_LAST)
                        state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d     = '0;
                    par_bit_d = rx_s_q;
                    state_d   = S_STOP;
                end
            end
            S_STOP: begin
                // Frame completes mid stop bit; IDLE can catch a start edge
                // right after, so back-to-back frames need only half a stop.
                if (cnt_q == CNT_LAST) begin
                    cnt_d     = '0;
                    data_d    = shift_q;
                    frm_err_d = ~rx_s_q;
                    par_err_d = (PARITY_EN != 0) && (par_calc != 1'(PARITY_ODD));
                    done_d    = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    assign data_o    = data_q;
    assign rx_done_o = done_q;
    assign par_err_o = par_err_q;
    assign frm_err_o = frm_err_q;
    assign busy_o    = (state_q != S_IDLE);

endmodule
